// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage (IF)
// and the memory stage (MEM). Only one requester is granted at a time, and
// this block drives the memory handshake for that requester. Data accesses
// have priority over fetches. A starvation counter forces a fetch grant after
// STARVE_MAX data grants in a row while the fetch is waiting. A watchdog
// aborts any access that the memory has not acknowledged within TIMEOUT busy
// cycles.
//
// State table
//   state | meaning
//   IDLE  | no access outstanding; mem_req low; arbitrate every cycle
//   IBUSY | fetch access outstanding; mem_* held; wait for mem_ready/abort
//   DBUSY | data access outstanding; mem_* held; wait for mem_ready/abort
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   if_req, if_addr       fetch request; the request is held until if_done
//   d_req, d_we, d_addr,  data request (load/store), store data
//   d_wdata
//   mem_req, mem_we,      registered memory request bus
//   mem_addr, mem_wdata
//   mem_ready, mem_rdata  memory completion and read data
//   if_done, d_done       one-cycle completion pulses (combinational)
//   rdata                 mem_rdata on a normal completion, else 0
//   err                   pulses with done when the watchdog aborted the access
//   if_stall, d_stall     freeze the requesting stage until its done

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              if_stall,
  output logic              d_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       WD_EN      = (TIMEOUT != 0);
  // Last wd_cnt value of a busy period: the TIMEOUT-th busy cycle sees
  // wd_cnt == TIMEOUT-1 because the count starts at 0 on the grant.
  localparam logic [7:0] WD_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [7:0]        wd_cnt, wd_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  logic busy;
  logic wd_expire;
  logic complete;
  logic arb_en;
  logic starved;
  logic grant_d;
  logic grant_i;

  assign busy      = (state != IDLE);
  // mem_ready takes precedence over an expiring watchdog in the same cycle.
  assign wd_expire = busy & WD_EN & ~mem_ready & (wd_cnt == WD_LAST);
  assign complete  = busy & (mem_ready | wd_expire);
  // Arbitrate while idle and on every completion so that back-to-back
  // grants need no idle cycle in between.
  assign arb_en    = (state == IDLE) | complete;
  assign starved   = if_req & (starve_cnt == STARVE_LIM);
  assign grant_d   = arb_en & d_req & ~starved;
  assign grant_i   = arb_en & if_req & ~grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= 4'd0;
      wd_cnt     <= 8'd0;
    end else begin
      state      <= state_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      starve_cnt <= starve_nxt;
      wd_cnt     <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    starve_nxt    = starve_cnt;
    wd_nxt        = wd_cnt;

    if (grant_d) begin
      state_nxt     = DBUSY;
      mem_req_nxt   = 1'b1;
      mem_we_nxt    = d_we;
      mem_addr_nxt  = d_addr;
      mem_wdata_nxt = d_wdata;
      wd_nxt        = 8'd0;
      // Only data grants that actually make a fetch wait count toward
      // starvation; an uncontested data grant restarts the count.
      if (if_req) begin
        if (starve_cnt != STARVE_LIM) begin
          starve_nxt = starve_cnt + 4'd1;
        end
      end else begin
        starve_nxt = 4'd0;
      end
    end else if (grant_i) begin
      state_nxt     = IBUSY;
      mem_req_nxt   = 1'b1;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = if_addr;
      mem_wdata_nxt = '0;
      wd_nxt        = 8'd0;
      starve_nxt    = 4'd0;
    end else if (arb_en) begin
      // Completion (or idle) with nobody asking: release the memory.
      state_nxt   = IDLE;
      mem_req_nxt = 1'b0;
    end else if (busy) begin
      // Busy without completion implies mem_ready is low this cycle.
      // Saturate so a disabled watchdog never wraps.
      if (wd_cnt != 8'hFF) begin
        wd_nxt = wd_cnt + 8'd1;
      end
    end
  end

  assign if_done  = (state == IBUSY) & complete;
  assign d_done   = (state == DBUSY) & complete;
  assign err      = wd_expire;
  assign rdata    = (complete & mem_ready) ? mem_rdata : '0;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'h5A5A_5A5A;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst_n;

  // main DUT: STARVE_MAX=4, TIMEOUT=8
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_req, mem_we, if_done, d_done, err, if_stall, d_stall;
  logic [31:0] mem_addr, mem_wdata, rdata;

  // second DUT: watchdog disabled
  logic        n_if_req, n_d_req, n_d_we, n_mem_ready;
  logic [31:0] n_if_addr, n_d_addr, n_d_wdata, n_mem_rdata;
  logic        n_mem_req, n_mem_we, n_if_done, n_d_done, n_err, n_if_stall, n_d_stall;
  logic [31:0] n_mem_addr, n_mem_wdata, n_rdata;

  always #5 clk = ~clk;

  assign mem_rdata   = mem_addr ^ K;
  assign n_mem_rdata = n_mem_addr ^ K;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_done(if_done), .d_done(d_done), .rdata(rdata), .err(err),
    .if_stall(if_stall), .d_stall(d_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(0)) u_nowd (
    .clk(clk), .rst_n(rst_n),
    .if_req(n_if_req), .if_addr(n_if_addr),
    .d_req(n_d_req), .d_we(n_d_we), .d_addr(n_d_addr), .d_wdata(n_d_wdata),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_ready(n_mem_ready), .mem_rdata(n_mem_rdata),
    .if_done(n_if_done), .d_done(n_d_done), .rdata(n_rdata), .err(n_err),
    .if_stall(n_if_stall), .d_stall(n_d_stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic is_d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic e, input logic [31:0] rd);
    exp_t x;
    x.is_d = is_d; x.we = we; x.addr = addr; x.wdata = wdata; x.err = e; x.rdata = rd;
    sb.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // scoreboard monitor: every done pulse on the main DUT consumes one expectation
  always @(negedge clk) begin
    if (rst_n && (if_done || d_done)) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done: got if_done=%0b d_done=%0b expected no done (t=%0t)",
                 if_done, d_done, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_done_kind", {62'd0, if_done, d_done}, e.is_d ? 64'd1 : 64'd2);
        chk("sb_mem_we",    {63'd0, mem_we},          {63'd0, e.we});
        chk("sb_mem_addr",  {32'd0, mem_addr},        {32'd0, e.addr});
        chk("sb_mem_wdata", {32'd0, mem_wdata},       {32'd0, e.wdata});
        chk("sb_err",       {63'd0, err},             {63'd0, e.err});
        chk("sb_rdata",     {32'd0, rdata},           {32'd0, e.rdata});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hits;
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_ready = 1;
    n_if_req = 0; n_if_addr = 0; n_d_req = 0; n_d_we = 0; n_d_addr = 0; n_d_wdata = 0;
    n_mem_ready = 0;

    // reset state
    repeat (3) @(posedge clk);
    neg();
    chk("rst_mem_req",   {63'd0, mem_req},   64'd0);
    chk("rst_mem_we",    {63'd0, mem_we},    64'd0);
    chk("rst_mem_addr",  {32'd0, mem_addr},  64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_dones",     {62'd0, if_done, d_done}, 64'd0);
    chk("rst_rdata",     {32'd0, rdata},     64'd0);
    chk("rst_nowd_req",  {63'd0, n_mem_req}, 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // single fetch, if_req kept for one extra access (back-to-back)
    if_req = 1; if_addr = 32'h40; mem_ready = 1;
    push(0, 0, 32'h40, 0, 0, 32'h40 ^ K);
    push(0, 0, 32'h40, 0, 0, 32'h40 ^ K);
    neg();
    chk("f_stall_c0", {63'd0, if_stall}, 64'd1);
    chk("f_req_c0",   {63'd0, mem_req},  64'd0);
    cyc();
    neg();
    chk("f_req_c1",   {63'd0, mem_req},  64'd1);
    chk("f_done_c1",  {63'd0, if_done},  64'd1);
    chk("f_stall_c1", {63'd0, if_stall}, 64'd0);
    cyc();
    if_req = 0;
    neg();
    chk("f_done_c2",  {63'd0, if_done},  64'd1);
    cyc();
    neg();
    chk("f_idle_c3",  {63'd0, mem_req},  64'd0);
    cyc();

    // conflict: D first, then I with no bubble
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    push(1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h100 ^ K);
    push(0, 0, 32'h80, 0, 0, 32'h80 ^ K);
    neg();
    chk("c_dstall_c0", {63'd0, d_stall}, 64'd1);
    cyc();
    d_req = 0; d_we = 0;
    neg();
    chk("c_ddone_c1",  {63'd0, d_done}, 64'd1);
    chk("c_starve_c1", {60'd0, u_dut.starve_cnt}, 64'd1);
    cyc();
    if_req = 0;
    neg();
    chk("c_idone_c2",  {63'd0, if_done}, 64'd1);
    chk("c_starve_c2", {60'd0, u_dut.starve_cnt}, 64'd0);
    cyc();
    neg();
    chk("c_idle_c3",   {63'd0, mem_req}, 64'd0);
    cyc();

    // starvation: 4 D, 1 I, repeated
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_wdata = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push(0, 0, 32'h200, 0, 0, 32'h200 ^ K);
      else                  push(1, 0, 32'h300, 0, 0, 32'h300 ^ K);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 10) begin
        if_req = 0; d_req = 0;
      end
      neg();
      if (k == 4) chk("s_starve_full", {60'd0, u_dut.starve_cnt}, 64'd4);
      if (k == 5) begin
        chk("s_starve_clr", {60'd0, u_dut.starve_cnt}, 64'd0);
        chk("s_idone_c5",   {63'd0, if_done}, 64'd1);
      end
    end
    cyc();
    neg();
    chk("s_idle", {63'd0, mem_req}, 64'd0);
    cyc();

    // watchdog abort in the 8th busy cycle
    d_req = 1; d_we = 0; d_addr = 32'h500; d_wdata = 32'h12345678; mem_ready = 0;
    push(1, 0, 32'h500, 32'h12345678, 1, 0);
    neg();
    chk("w_dstall_c0", {63'd0, d_stall}, 64'd1);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) d_req = 0;
      neg();
      if (k == 7) chk("w_noerr_c7", {62'd0, err, d_done}, 64'd0);
      if (k == 8) chk("w_err_c8",   {62'd0, err, d_done}, 64'd3);
      if (k == 9) chk("w_idle_c9",  {63'd0, mem_req}, 64'd0);
    end
    cyc();

    // mem_ready and expiry in the same cycle: normal completion
    d_req = 1; d_we = 0; d_addr = 32'h600; d_wdata = 0; mem_ready = 0;
    push(1, 0, 32'h600, 0, 0, 32'h600 ^ K);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) d_req = 0;
      if (k == 8) mem_ready = 1;
      if (k == 9) mem_ready = 0;
      neg();
      if (k == 8) chk("x_done_noerr", {62'd0, err, d_done}, 64'd1);
      if (k == 9) chk("x_idle",       {63'd0, mem_req}, 64'd0);
    end
    cyc();

    // async reset during DBUSY
    if_req = 1; if_addr = 32'h900;
    d_req = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'hCAFE; mem_ready = 0;
    cyc();
    d_req = 0;
    neg();
    chk("r_busy_req",   {63'd0, mem_req}, 64'd1);
    chk("r_starve_pre", {60'd0, u_dut.starve_cnt}, 64'd1);
    @(posedge clk);
    #3;
    rst_n = 0; if_req = 0; mem_ready = 1;
    #1;
    chk("r_async_req",  {63'd0, mem_req}, 64'd0);
    neg();
    chk("r_in_rst_out", {29'd0, if_done, d_done, err, rdata}, 64'd0);
    chk("r_starve_rst", {60'd0, u_dut.starve_cnt}, 64'd0);
    chk("r_addr_rst",   {32'd0, mem_addr}, 64'd0);
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    if_req = 1; if_addr = 32'h900; mem_ready = 1;
    push(0, 0, 32'h900, 0, 0, 32'h900 ^ K);
    neg();
    chk("r_idle_after", {63'd0, mem_req}, 64'd0);
    cyc();
    if_req = 0;
    neg();
    chk("r_first_fetch", {63'd0, if_done}, 64'd1);
    chk("r_starve_post", {60'd0, u_dut.starve_cnt}, 64'd0);
    cyc();
    neg();
    chk("r_idle_end", {63'd0, mem_req}, 64'd0);
    cyc();

    // watchdog disabled: no abort in 300 cycles
    n_d_req = 1; n_d_we = 0; n_d_addr = 32'h44; n_mem_ready = 0;
    cyc();
    n_d_req = 0;
    hits = 0;
    for (int k = 0; k < 300; k++) begin
      neg();
      if (n_d_done || n_err) hits++;
      cyc();
    end
    chk("n_no_abort",  hits, 64'd0);
    chk("n_still_req", {63'd0, n_mem_req}, 64'd1);
    n_mem_ready = 1;
    neg();
    chk("n_done_late", {62'd0, n_err, n_d_done}, 64'd1);
    chk("n_rdata",     {32'd0, n_rdata}, {32'd0, 32'h44 ^ K});
    cyc();
    n_mem_ready = 0;
    neg();
    chk("n_idle", {63'd0, n_mem_req}, 64'd0);

    chk("sb_empty", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
